// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALUFun codes, MULT/DIV selectors and FSM state encoding.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [5:0] FN_ADD  = 6'b000000;
    localparam logic [5:0] FN_SUB  = 6'b000001;
    localparam logic [5:0] FN_AND  = 6'b011000;
    localparam logic [5:0] FN_OR   = 6'b011110;
    localparam logic [5:0] FN_XOR  = 6'b010110;
    localparam logic [5:0] FN_NOR  = 6'b010001;
    localparam logic [5:0] FN_PASA = 6'b011010;
    localparam logic [5:0] FN_SLL  = 6'b100000;
    localparam logic [5:0] FN_SRL  = 6'b100001;
    localparam logic [5:0] FN_SRA  = 6'b100011;
    localparam logic [5:0] FN_EQ   = 6'b110011;
    localparam logic [5:0] FN_NEQ  = 6'b110001;
    localparam logic [5:0] FN_LT   = 6'b110101;
    localparam logic [5:0] FN_LEZ  = 6'b111101;
    localparam logic [5:0] FN_LTZ  = 6'b111011;
    localparam logic [5:0] FN_GTZ  = 6'b111111;

    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } md_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_md_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_md_iter
// Purpose  : Radix-2 iterative multiply / restoring divide with sign fix-up.
// Revision : 1.0
// ============================================================================
module alu_md_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             op,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             last
);

    logic [WIDTH-1:0]   r_hi, r_lo, r_b;
    logic               r_op, r_neg_q, r_neg_r;
    logic [SHW-1:0]     r_cnt;

    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_add, w_trial, w_sub;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;

    assign w_a_mag = (sign && a[WIDTH-1]) ? -a : a;
    assign w_b_mag = (sign && b[WIDTH-1]) ? -b : b;
    assign w_add   = {1'b0, r_hi} + {1'b0, r_b};
    // Divide: shift the next dividend bit into the partial remainder and trial-subtract.
    assign w_trial = {r_hi, r_lo[WIDTH-1]};
    assign w_sub   = w_trial - {1'b0, r_b};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
            r_op    <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_cnt   <= '0;
        end else if (load) begin
            r_hi    <= '0;
            r_lo    <= w_a_mag;
            r_b     <= w_b_mag;
            r_op    <= op;
            r_neg_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r <= sign & a[WIDTH-1];
            r_cnt   <= '0;
        end else if (step) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_op == MD_MULT) begin
                if (r_lo[0]) begin
                    {r_hi, r_lo} <= {w_add, r_lo[WIDTH-1:1]};
                end else begin
                    {r_hi, r_lo} <= {1'b0, r_hi, r_lo[WIDTH-1:1]};
                end
            end else if (!w_sub[WIDTH]) begin
                r_hi <= w_sub[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                r_hi <= w_trial[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

    assign hi   = (r_op == MD_MULT) ? w_prod_fix[2*WIDTH-1:WIDTH] : (r_neg_r ? -r_hi : r_hi);
    assign lo   = (r_op == MD_MULT) ? w_prod_fix[WIDTH-1:0]       : (r_neg_q ? -r_lo : r_lo);
    assign last = (r_cnt == SHW'(WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Purpose  : Registered ALUFun unit plus iterative MULT/DIV, start/busy/done.
// Revision : 1.0
// ============================================================================
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             md_en,
    input  logic             md_op,
    input  logic [5:0]       ALUFun,
    input  logic             Sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ovf,
    output logic             dbz
);

    logic             r_req, r_md, r_mdop, r_sign;
    logic [5:0]       r_fun;
    logic [WIDTH-1:0] r_a, r_b;
    md_state_t        r_state, w_next;
    logic             r_dbz_op, r_done, r_done_md;
    logic [WIDTH-1:0] r_result, r_hi, r_lo;
    logic             r_ovf, r_dbz;

    logic             w_accept, w_is_dbz, w_load, w_step, w_md_fin, w_alu_fin, w_last;
    logic [WIDTH-1:0] w_alu_res, w_md_hi, w_md_lo;
    logic             w_alu_ovf;
    logic [WIDTH:0]   w_sum, w_dif;
    logic [SHW-1:0]   w_sh;

    // A captured MULT/DIV request blocks capture until the FSM raises busy.
    assign w_accept  = start & ~busy & ~(r_req & r_md);
    assign w_is_dbz  = (r_mdop == MD_DIV) && (r_b == '0);
    assign w_alu_fin = r_req & ~r_md;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req  <= 1'b0;
            r_md   <= 1'b0;
            r_mdop <= 1'b0;
            r_sign <= 1'b0;
            r_fun  <= '0;
            r_a    <= '0;
            r_b    <= '0;
        end else begin
            r_req <= w_accept;
            if (w_accept) begin
                r_md   <= md_en;
                r_mdop <= md_op;
                r_sign <= Sign;
                r_fun  <= ALUFun;
                r_a    <= A;
                r_b    <= B;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_md_fin = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_req && r_md) begin
                    if (w_is_dbz) begin
                        w_next = FIX;
                    end else begin
                        w_next = ITER;
                        w_load = 1'b1;
                    end
                end
            end
            ITER: begin
                w_step = 1'b1;
                if (w_last) w_next = FIX;
            end
            FIX: begin
                w_md_fin = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    alu_md_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_md (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .op    (r_mdop),
        .sign  (r_sign),
        .a     (r_a),
        .b     (r_b),
        .step  (w_step),
        .hi    (w_md_hi),
        .lo    (w_md_lo),
        .last  (w_last)
    );

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};
    assign w_dif = {1'b0, r_a} - {1'b0, r_b};
    assign w_sh  = r_a[SHW-1:0];

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (r_fun)
            FN_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_ovf = r_sign ? ((r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]))
                                   : w_sum[WIDTH];
            end
            FN_SUB: begin
                w_alu_res = w_dif[WIDTH-1:0];
                w_alu_ovf = r_sign ? ((r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_dif[WIDTH-1] != r_a[WIDTH-1]))
                                   : w_dif[WIDTH];
            end
            FN_AND:  w_alu_res = r_a & r_b;
            FN_OR:   w_alu_res = r_a | r_b;
            FN_XOR:  w_alu_res = r_a ^ r_b;
            FN_NOR:  w_alu_res = ~(r_a | r_b);
            FN_PASA: w_alu_res = r_a;
            FN_SLL:  w_alu_res = r_b << w_sh;
            FN_SRL:  w_alu_res = r_b >> w_sh;
            FN_SRA:  w_alu_res = $signed(r_b) >>> w_sh;
            FN_EQ:   w_alu_res = WIDTH'(r_a == r_b);
            FN_NEQ:  w_alu_res = WIDTH'(r_a != r_b);
            FN_LT:   w_alu_res = WIDTH'(r_sign ? ($signed(r_a) < $signed(r_b)) : (r_a < r_b));
            FN_LEZ:  w_alu_res = WIDTH'(r_a[WIDTH-1] | (r_a == '0));
            FN_LTZ:  w_alu_res = WIDTH'(r_a[WIDTH-1]);
            FN_GTZ:  w_alu_res = WIDTH'(~r_a[WIDTH-1] & (r_a != '0));
            default: w_alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dbz_op  <= 1'b0;
            r_done    <= 1'b0;
            r_done_md <= 1'b0;
            r_result  <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_ovf     <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done    <= w_alu_fin | w_md_fin;
            r_done_md <= w_md_fin;
            if (r_state == IDLE && r_req && r_md) r_dbz_op <= w_is_dbz;
            if (w_alu_fin) begin
                r_result <= w_alu_res;
                r_ovf    <= w_alu_ovf;
                r_dbz    <= 1'b0;
            end
            if (w_md_fin) begin
                r_ovf <= 1'b0;
                r_dbz <= r_dbz_op;
                r_hi  <= r_dbz_op ? r_a : w_md_hi;
                r_lo  <= r_dbz_op ? '1  : w_md_lo;
            end
        end
    end

    // busy stays high through the MULT/DIV done cycle so a start there is dropped.
    assign busy   = (r_state != IDLE) | r_done_md;
    assign done   = r_done;
    assign result = r_result;
    assign hi     = r_hi;
    assign lo     = r_lo;
    assign ovf    = r_ovf;
    assign dbz    = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_multicycle
// Purpose  : Randomised scoreboard bench for alu_multicycle (WIDTH 32 and 8).
// Revision : 1.0
// ============================================================================
module tb_alu_multicycle;

    typedef struct {
        int          cyc;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          ovf;
        bit          dbz;
    } exp_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        reset, start, md_en, md_op, Sign;
    logic [5:0]  ALUFun;
    logic [31:0] A, B;
    logic        busy, done, ovf, dbz;
    logic [31:0] result, hi, lo;

    logic        start8, op8, s8, busy8, done8, ovf8, dbz8;
    logic [7:0]  a8, b8, result8, hi8, lo8;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    logic [31:0] m_result, m_hi, m_lo;
    bit          m_ovf, m_dbz;

    logic [5:0] codes [18] = '{6'b000000, 6'b000001, 6'b011000, 6'b011110, 6'b010110, 6'b010001,
                               6'b011010, 6'b100000, 6'b100001, 6'b100011, 6'b110011, 6'b110001,
                               6'b110101, 6'b111101, 6'b111011, 6'b111111, 6'b000010, 6'b111110};

    alu_multicycle #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .md_en(md_en), .md_op(md_op),
        .ALUFun(ALUFun), .Sign(Sign), .A(A), .B(B), .busy(busy), .done(done),
        .result(result), .hi(hi), .lo(lo), .ovf(ovf), .dbz(dbz)
    );

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .md_en(1'b1), .md_op(op8),
        .ALUFun(6'b000000), .Sign(s8), .A(a8), .B(b8), .busy(busy8), .done(done8),
        .result(result8), .hi(hi8), .lo(lo8), .ovf(ovf8), .dbz(dbz8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    function automatic void alu_ref(input logic [5:0] f, input bit s, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r, output bit o);
        longint sa, sb, ua, ub;
        int     sh;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        sh = int'(a[4:0]);
        r  = '0;
        o  = 1'b0;
        case (f)
            6'b000000: begin r = 32'(ua + ub); o = s ? (sa + sb > SMAX || sa + sb < SMIN) : (ua + ub > 64'hFFFFFFFF); end
            6'b000001: begin r = 32'(ua - ub); o = s ? (sa - sb > SMAX || sa - sb < SMIN) : (ua < ub); end
            6'b011000: r = a & b;
            6'b011110: r = a | b;
            6'b010110: r = a ^ b;
            6'b010001: r = ~(a | b);
            6'b011010: r = a;
            6'b100000: r = b << sh;
            6'b100001: r = b >> sh;
            6'b100011: r = 32'(sb >>> sh);
            6'b110011: r = (a == b) ? 32'd1 : 32'd0;
            6'b110001: r = (a != b) ? 32'd1 : 32'd0;
            6'b110101: r = (s ? (sa < sb) : (ua < ub)) ? 32'd1 : 32'd0;
            6'b111101: r = (sa <= 0) ? 32'd1 : 32'd0;
            6'b111011: r = (sa < 0) ? 32'd1 : 32'd0;
            6'b111111: r = (sa > 0) ? 32'd1 : 32'd0;
            default:   r = '0;
        endcase
    endfunction

    function automatic void md_ref(input int w, input bit s, input bit op,
                                   input longint unsigned a, input longint unsigned b,
                                   output longint unsigned rhi, output longint unsigned rlo,
                                   output bit dz);
        longint unsigned msk;
        longint          half, sa, sb, p;
        msk  = (64'd1 << w) - 64'd1;
        half = longint'(64'd1 << (w - 1));
        sa   = s ? (longint'(a ^ (64'd1 << (w - 1))) - half) : longint'(a);
        sb   = s ? (longint'(b ^ (64'd1 << (w - 1))) - half) : longint'(b);
        dz   = 1'b0;
        if (!op) begin
            p   = sa * sb;
            rlo = $unsigned(p) & msk;
            rhi = ($unsigned(p) >> w) & msk;
        end else if (b == 0) begin
            dz  = 1'b1;
            rhi = a;
            rlo = msk;
        end else if (s && sa == -half && sb == -1) begin
            rlo = $unsigned(-half) & msk;
            rhi = 0;
        end else begin
            rlo = $unsigned(sa / sb) & msk;
            rhi = $unsigned(sa % sb) & msk;
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'h7FFFFFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    function automatic void push(input int lat);
        exp_t e;
        e.cyc = cyc + 1 + lat;
        e.res = m_result;
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.ovf = m_ovf;
        e.dbz = m_dbz;
        sb_q.push_back(e);
    endfunction

    // Called 1 time unit after a rising edge; leaves start high for back-to-back ops.
    task automatic issue_alu(input logic [5:0] f, input bit s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        bit          o;
        alu_ref(f, s, a, b, r, o);
        m_result = r;
        m_ovf    = o;
        m_dbz    = 1'b0;
        push(1);
        start = 1'b1; md_en = 1'b0; md_op = 1'($urandom); ALUFun = f; Sign = s; A = a; B = b;
        @(posedge clk); #1;
    endtask

    task automatic issue_md(input bit s, input bit op, input logic [31:0] a, input logic [31:0] b, input bit spam);
        longint unsigned rh, rl;
        bit  dz;
        int  lat, bad;
        md_ref(32, s, op, a, b, rh, rl, dz);
        lat   = dz ? 2 : 34;
        bad   = 0;
        m_hi  = rh[31:0];
        m_lo  = rl[31:0];
        m_ovf = 1'b0;
        m_dbz = dz;
        push(lat);
        start = 1'b1; md_en = 1'b1; md_op = op; Sign = s; A = a; B = b; ALUFun = 6'($urandom);
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom; Sign = 1'($urandom); md_op = 1'($urandom);
        for (int n = 1; n <= lat + 1; n++) begin
            @(posedge clk); #1;
            if (busy !== (n <= lat)) bad++;
            if (spam && n <= lat && busy === 1'b1 && $urandom_range(0, 2) == 0) begin
                start = 1'b1; md_en = 1'($urandom); md_op = 1'($urandom);
                ALUFun = codes[$urandom_range(0, 17)]; A = $urandom; B = $urandom; Sign = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("md_busy_window", 64'(bad), 64'd0);
    endtask

    task automatic run8(input bit s, input bit op, input logic [7:0] a, input logic [7:0] b);
        longint unsigned rh, rl;
        bit dz, got;
        int n;
        md_ref(8, s, op, a, b, rh, rl, dz);
        start8 = 1'b1; s8 = s; op8 = op; a8 = a; b8 = b;
        n   = 0;
        got = 1'b0;
        while (n < 30 && !got) begin
            @(posedge clk); #1;
            start8 = 1'b0;
            n++;
            got = done8;
        end
        chk("w8_done_seen", 64'(got), 64'd1);
        chk("w8_latency", 64'(n - 1), dz ? 64'd2 : 64'd10);
        chk("w8_hi", 64'(hi8), rh);
        chk("w8_lo", 64'(lo8), rl);
        chk("w8_dbz", 64'(dbz8), 64'(dz));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no completion", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("result", 64'(result), 64'(e.res));
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
                chk("ovf", 64'(ovf), 64'(e.ovf));
                chk("dbz", 64'(dbz), 64'(e.dbz));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; md_en = 1'b0; md_op = 1'b0; ALUFun = '0; Sign = 1'b0; A = '0; B = '0;
        start8 = 1'b0; op8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;
        m_result = '0; m_hi = '0; m_lo = '0; m_ovf = 1'b0; m_dbz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {27'd0, busy, done, ovf, dbz, 1'b0, result | hi | lo}, 64'd0);
        chk("reset_outputs_w8", {49'd0, busy8, done8, ovf8, dbz8, 3'd0, result8 | hi8 | lo8}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        issue_alu(6'b000000, 1'b1, 32'h7FFFFFFF, 32'h1);
        issue_alu(6'b000000, 1'b0, 32'h7FFFFFFF, 32'h1);
        issue_alu(6'b100011, 1'b0, 32'h4, 32'hF0000000);
        issue_alu(6'b110101, 1'b0, 32'h1, 32'hFFFFFFFF);
        issue_alu(6'b110101, 1'b1, 32'h1, 32'hFFFFFFFF);
        issue_md(1'b1, 1'b0, 32'hFFFFFFFD, 32'h7, 1'b1);
        issue_md(1'b1, 1'b1, 32'hFFFFFFF9, 32'h2, 1'b1);
        issue_md(1'b0, 1'b1, 32'h5, 32'h0, 1'b0);
        issue_md(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0)
                issue_md(1'($urandom), 1'($urandom), pick(), pick(), 1'($urandom));
            else
                issue_alu(codes[$urandom_range(0, 17)], 1'($urandom), pick(), pick());
        end
        start = 1'b0;
        drain();

        // Abort a MULT mid-iteration; no completion may follow.
        start = 1'b1; md_en = 1'b1; md_op = 1'b0; Sign = 1'($urandom); A = $urandom; B = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_outputs", {27'd0, busy, done, ovf, dbz, 1'b0, result | hi | lo}, 64'd0);
        m_result = '0; m_hi = '0; m_lo = '0; m_ovf = 1'b0; m_dbz = 1'b0;
        issue_alu(6'b000000, 1'b0, 32'd20, 32'd22);
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        drain();

        run8(1'b0, 1'b0, 8'hFF, 8'hFF);
        run8(1'b1, 1'b1, 8'h80, 8'hFF);
        run8(1'b0, 1'b1, 8'h05, 8'h00);
        for (int i = 0; i < 12; i++) run8(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom_range(0, 255)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, registered successor to the single-cycle CPU ALU. It executes the existing ALUFun add/logic/shift/compare set in one cycle and adds iterative MULT/DIV with HI/LO results, overflow and divide-by-zero flags. Operation uses a start/busy/done handshake. It sits in the EX stage; the pipeline stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand/result width. Must be ≥ 4 and a power of two.
- `SHW`, default $clog2(WIDTH): shift-amount width. Derived; do not override.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch op. Sampled only when `busy`=0.
- `md_en`  in  1  1 selects MULT/DIV; 0 selects the ALUFun op.
- `md_op`  in  1  0=MULT, 1=DIV. Ignored when `md_en`=0.
- `ALUFun`  in  6  op select, encoding below.
- `Sign`  in  1  1 = signed arithmetic, compare, MULT and DIV.
- `A`, `B`  in  WIDTH  operands. Shift amount is `A[SHW-1:0]`; the shifted value is `B`.
- `busy`  out  1  op in flight; `start` is ignored while set.
- `done`  out  1  one-cycle pulse; outputs are valid from this cycle.
- `result`  out  WIDTH  ALUFun result.
- `hi`, `lo`  out  WIDTH  MULT: product high/low. DIV: remainder/quotient.
- `ovf`  out  1  add/sub overflow, per `Sign`.
- `dbz`  out  1  DIV with `B`=0.

## Operation
- ALUFun encoding:
  - ADD 000000, SUB 000001.
  - AND 011000, OR 011110, XOR 010110, NOR 010001, PASS-A 011010.
  - SLL 100000, SRL 100001, SRA 100011.
  - EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.
  - Any other code → `result`=0.
- Compare results are zero-extended 0/1. LT honours `Sign`. LEZ/LTZ/GTZ test `A` as signed.
- `ovf`:
  - Signed: set when the sign of the true sum differs from the WIDTH-bit result.
  - Unsigned: carry-out for ADD, borrow for SUB.
  - 0 for non-add ops.
- MULT: full 2·WIDTH product into {`hi`,`lo`}. With `Sign`=1, two's-complement product.
- DIV:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed MIN/−1 → `lo`=MIN, `hi`=0, no flag.
- MULT/DIV datapath: the setup cycle takes magnitudes, then WIDTH radix-2 iterations (shift-add / restoring subtract), then a sign-fix cycle.
- State machine:
  - IDLE →(`start`&`md_en`)→ ITER.
  - ITER →(count = WIDTH−1)→ FIX.
  - FIX → IDLE.
  - IDLE →(`start`&!`md_en`)→ IDLE, with outputs registered in one cycle.
  - DIV with `B`=0: IDLE → FIX directly. `dbz`=1, `hi`=`A`, `lo`=all ones.
- Operands, `Sign` and op are captured at the start edge; later input changes have no effect.
- Outputs hold until the next completion. An ALU op leaves `hi`/`lo` untouched; MULT/DIV leaves `result` untouched.
- `ovf` updates on every completion; it is cleared on MULT/DIV completion. `dbz` likewise, cleared on any non-dbz completion.

## Timing
- Reset values: all outputs 0, state IDLE, count 0.
- Reset during ITER/FIX aborts the op with no `done` pulse; the next `start` is accepted the cycle after reset deasserts.
- Latency, with `start` sampled at edge 0:
  - ALU op: `done`=1 in the cycle after edge 1.
  - MULT/DIV: `done` after edge WIDTH+2; `busy`=1 from after edge 1 through the `done` cycle.
  - DIV by zero: `done` after edge 2.
- Back-to-back: `start` may be asserted in the `done` cycle of a multi-cycle op only once `busy` falls. `busy` is low in the `done` cycle of ALU ops, so ALU ops sustain one per cycle.
- `start` with `busy`=1 is dropped silently; there is no queueing.

## Structure
- Package `alu_pkg`:
  - ALUFun localparams.
  - MD_MULT/MD_DIV codes.
  - State enum (IDLE, ITER, FIX).
- Sub-module `alu_md_iter`: iterative multiply/divide datapath and counter. Ports: load, op, sign, a, b, step, hi, lo, last.
- The top level holds the combinational ALUFun unit, the FSM and the output registers.

## Test plan
- ADD, `Sign`=1, A=0x7FFFFFFF, B=1 → `result`=0x80000000, `ovf`=1, `done` one cycle after start. Same operands with `Sign`=0 → `ovf`=0.
- SRA A=4, B=0xF0000000 → `result`=0xFF000000. LT `Sign`=0, A=1, B=0xFFFFFFFF → `result`=1. LT `Sign`=1, same operands → `result`=0.
- MULT `Sign`=1, A=−3, B=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `done` 34 cycles after start, `busy` high throughout.
- DIV `Sign`=1, A=−7, B=2 → `lo`=−3, `hi`=−1. DIV `Sign`=0, A=5, B=0 → `dbz`=1, `hi`=5, `lo`=0xFFFFFFFF, `done` 2 cycles after start.
- `start` pulses during MULT busy → ignored. `reset` at iteration 10 → no `done`, outputs 0; a new ADD issued right after completes correctly.
- WIDTH=8: MULT `Sign`=0, 0xFF×0xFF → `hi`=0xFE, `lo`=0x01, `done` 10 cycles after start.
